// File: rtl/orb_pkg.sv
// rtl/orb_pkg.sv - shared ORB pipeline constants and corner-delay state encoding
package orb_pkg;

   localparam int IMG_W               = 640;
   localparam int IMG_H               = 480;
   localparam int FRAME_PIXELS        = IMG_W * IMG_H;
   localparam int DELAY               = 11502;
   localparam int WIDTH_DELAY_ADDRESS = 14;
   localparam int CNT_W               = 19;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      RUN   = 2'd2,
      FLUSH = 2'd3
   } cdc_state_t;

endpackage

// File: rtl/Delay_D.sv
// rtl/Delay_D.sv - enable-driven circular-buffer delay line of D pushes
module Delay_D #(
   parameter int WIDTH = 1,
   parameter int D     = 4,
   parameter int B     = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   localparam logic [B-1:0] LAST = B'(D - 1);

   logic [WIDTH-1:0] mem [0:D-1];
   logic [B-1:0]     ptr;

   // The slot about to be overwritten holds the sample pushed D enables ago.
   assign dout = mem[ptr];

   // Pointer advances once per push and wraps after D slots.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (ena) begin
         ptr <= (ptr == LAST) ? '0 : ptr + B'(1);
      end
   end

   // Storage is never cleared; the controller masks stale contents.
   always_ff @(posedge clk) begin
      if (ena) begin
         mem[ptr] <= din;
      end
   end

endmodule

// File: rtl/corner_delay_ctrl.sv
// rtl/corner_delay_ctrl.sv - primes, runs and flushes the corner-flag delay line per frame
module corner_delay_ctrl #(
   parameter int DELAY               = orb_pkg::DELAY,
   parameter int WIDTH_DELAY_ADDRESS = orb_pkg::WIDTH_DELAY_ADDRESS,
   parameter int FRAME_PIXELS        = orb_pkg::FRAME_PIXELS,
   parameter int CNT_W               = orb_pkg::CNT_W
) (
   input  logic clk,
   input  logic rst,
   input  logic frame_start,
   input  logic in_valid,
   output logic in_ready,
   input  logic in_corner,
   input  logic out_ready,
   output logic out_valid,
   output logic out_corner,
   output logic busy,
   output logic frame_done
);

   import orb_pkg::*;

   localparam logic [CNT_W-1:0] DELAY_C     = CNT_W'(DELAY);
   localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(DELAY - 1);
   localparam logic [CNT_W-1:0] PIXELS_LAST = CNT_W'(FRAME_PIXELS - 1);

   cdc_state_t       state, state_nx;
   logic [CNT_W-1:0] fill_cnt, pix_cnt, flush_cnt;
   logic             ena, push_data, line_out, fill_full, done_pend;

   assign fill_full = (fill_cnt == DELAY_C);
   assign busy      = (state != IDLE);

   Delay_D #(
      .WIDTH (1),
      .D     (DELAY),
      .B     (WIDTH_DELAY_ADDRESS)
   ) u_delay (
      .clk  (clk),
      .rst  (rst),
      .ena  (ena),
      .din  (push_data),
      .dout (line_out)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next state, handshake and delay-line push selection.
   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      ena       = 1'b0;
      push_data = 1'b0;
      case (state)
         IDLE: begin
            if (frame_start) state_nx = FILL;
         end
         FILL: begin
            // No output is produced while priming, so no back-pressure applies.
            in_ready  = 1'b1;
            ena       = in_valid;
            push_data = in_corner;
            if (ena && fill_cnt == DELAY_LAST) state_nx = RUN;
         end
         RUN: begin
            in_ready  = out_ready;
            ena       = in_valid & out_ready;
            push_data = in_corner;
            if (ena && pix_cnt == PIXELS_LAST) state_nx = FLUSH;
         end
         FLUSH: begin
            // Zeros drain the tail of the frame out of the line.
            ena       = out_ready;
            push_data = 1'b0;
            if (ena && flush_cnt == DELAY_LAST) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Fill, pixel and flush counters; all restart when the frame ends.
   always_ff @(posedge clk) begin
      if (rst || state_nx == IDLE) begin
         fill_cnt  <= '0;
         pix_cnt   <= '0;
         flush_cnt <= '0;
      end else if (ena) begin
         if (!fill_full)      fill_cnt  <= fill_cnt + CNT_W'(1);
         if (state == FLUSH)  flush_cnt <= flush_cnt + CNT_W'(1);
         else                 pix_cnt   <= pix_cnt + CNT_W'(1);
      end
   end

   // Registered output strobe and flag; flag is masked until the line is primed.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_corner <= 1'b0;
      end else begin
         out_valid <= ena & fill_full;
         if (ena && fill_full) begin
            out_corner <= line_out;
         end else if (!fill_full) begin
            out_corner <= 1'b0;
         end
      end
   end

   // frame_done trails the final strobe by one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         done_pend  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         done_pend  <= (state == FLUSH) && (state_nx == IDLE);
         frame_done <= done_pend;
      end
   end

endmodule
